// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for a 5-stage pipeline.
// Tracks destination info for the stages ahead of ID and drives registered ALU operand selects.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ext_stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    typedef enum logic [1:0] {
        ACT_ADV,
        ACT_HOLD,
        ACT_FLUSH,
        ACT_LU
    } act_e;

    // Only EX and MEM copies are kept: an instruction already in WB is never a forwarding source.
    logic [REG_AW-1:0] ex_rd_reg;
    logic              ex_rw_reg;
    logic              ex_mr_reg;
    logic [REG_AW-1:0] mem_rd_reg;
    logic              mem_rw_reg;
    logic [1:0]        fwd_a_reg;
    logic [1:0]        fwd_b_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;

    logic [2*REG_AW-1:0] src_vec;
    logic [1:0]          used_vec;
    logic [1:0]          lu_hit;
    logic [3:0]          sel_next;
    logic                ex_is_load;
    logic                lu;
    act_e                act;

    assign src_vec    = {id_rt, id_rs};
    assign used_vec   = {id_uses_rt, id_uses_rs};
    assign ex_is_load = ex_mr_reg && ex_rw_reg && (ex_rd_reg != '0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [REG_AW-1:0] src;
            logic [1:0]        sel;

            assign src = src_vec[gi*REG_AW +: REG_AW];
            // ex_is_load already excludes r0, so a match here implies a non-zero source
            assign lu_hit[gi] = used_vec[gi] && ex_is_load && (src == ex_rd_reg);

            always_comb begin
                sel = SEL_RF;
                if (used_vec[gi] && (src != '0)) begin
                    if (ex_rw_reg && !ex_mr_reg && (ex_rd_reg == src)) begin
                        sel = SEL_MEM;
                    end else if (mem_rw_reg && (mem_rd_reg == src)) begin
                        sel = SEL_WB;
                    end
                end
            end

            assign sel_next[gi*2 +: 2] = sel;
        end
    endgenerate

    assign lu = id_valid && (|lu_hit);

    always_comb begin
        act = ACT_ADV;
        if (ext_stall) begin
            act = ACT_HOLD;
        end else if (flush) begin
            act = ACT_FLUSH;
        end else if (lu) begin
            act = ACT_LU;
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        if (!reset) begin
            unique case (act)
                ACT_HOLD: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                end
                ACT_FLUSH: begin
                    idex_bubble = 1'b1;
                end
                ACT_LU: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rd_reg     <= '0;
            ex_rw_reg     <= 1'b0;
            ex_mr_reg     <= 1'b0;
            mem_rd_reg    <= '0;
            mem_rw_reg    <= 1'b0;
            fwd_a_reg     <= SEL_RF;
            fwd_b_reg     <= SEL_RF;
            stall_cnt_reg <= '0;
        end else if (act != ACT_HOLD) begin
            mem_rd_reg <= ex_rd_reg;
            mem_rw_reg <= ex_rw_reg;
            if (act == ACT_ADV) begin
                ex_rd_reg <= id_rd;
                ex_rw_reg <= id_valid && id_regwrite;
                ex_mr_reg <= id_valid && id_memread;
                fwd_a_reg <= sel_next[1:0];
                fwd_b_reg <= sel_next[3:2];
            end else begin
                ex_rd_reg <= '0;
                ex_rw_reg <= 1'b0;
                ex_mr_reg <= 1'b0;
                fwd_a_reg <= SEL_RF;
                fwd_b_reg <= SEL_RF;
            end
            // A flush hides any coincident load-use, so only a real bubble is counted
            if ((act == ACT_LU) && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    assign fwd_a       = fwd_a_reg;
    assign fwd_b       = fwd_b_reg;
    assign stall_count = stall_cnt_reg;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed vector table, saturation sequence, then random
// stimulus against a stage-list reference model.
module tb_fwd_hazard_ctrl;

    localparam int REG_AW  = 5;
    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, ext_stall, flush, id_valid;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic              id_uses_rs, id_uses_rt, id_regwrite, id_memread;
    logic [1:0]        fwd_a, fwd_b;
    logic              pc_write, ifid_write, idex_bubble;
    logic [CNT_W-1:0]  stall_count;

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    fwd_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .ext_stall(ext_stall), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_bubble(idex_bubble), .stall_count(stall_count)
    );

    typedef struct {
        logic rst, est, fl, v;
        logic [4:0] rs, rt;
        logic urs, urt;
        logic [4:0] rd;
        logic rw, mr;
    } in_t;

    typedef struct {
        logic pw, iw, bb;
        logic [1:0] fa, fb;
        int sc;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    // Producer record for the model: one entry per stage ahead of ID (index 0 = EX, 1 = MEM)
    typedef struct {
        logic rw, mr;
        logic [4:0] rd;
    } prod_t;

    prod_t      m_stage [2];
    logic [1:0] m_fa, m_fb;
    int         m_cnt;

    function automatic vec_t row(input logic rst, est, fl, v, input int rs, rt,
                                 input logic urs, urt, input int rd, input logic rw, mr,
                                 input logic pw, iw, bb, input int fa, fb, sc);
        vec_t r;
        r.i.rst = rst; r.i.est = est; r.i.fl = fl; r.i.v = v;
        r.i.rs = 5'(rs); r.i.rt = 5'(rt); r.i.urs = urs; r.i.urt = urt;
        r.i.rd = 5'(rd); r.i.rw = rw; r.i.mr = mr;
        r.e.pw = pw; r.e.iw = iw; r.e.bb = bb;
        r.e.fa = 2'(fa); r.e.fb = 2'(fb); r.e.sc = sc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic apply(input in_t x, input exp_t e, input string tag);
        @(negedge clk);
        reset = x.rst; ext_stall = x.est; flush = x.fl; id_valid = x.v;
        id_rs = x.rs; id_rt = x.rt; id_uses_rs = x.urs; id_uses_rt = x.urt;
        id_rd = x.rd; id_regwrite = x.rw; id_memread = x.mr;
        #1;
        chk($sformatf("%s#%0d.pc_write", tag, n_txn), 32'(pc_write), 32'(e.pw));
        chk($sformatf("%s#%0d.ifid_write", tag, n_txn), 32'(ifid_write), 32'(e.iw));
        chk($sformatf("%s#%0d.idex_bubble", tag, n_txn), 32'(idex_bubble), 32'(e.bb));
        @(posedge clk);
        #1;
        chk($sformatf("%s#%0d.fwd_a", tag, n_txn), 32'(fwd_a), 32'(e.fa));
        chk($sformatf("%s#%0d.fwd_b", tag, n_txn), 32'(fwd_b), 32'(e.fb));
        chk($sformatf("%s#%0d.stall_count", tag, n_txn), 32'(stall_count), 32'(e.sc));
        $display("txn %0d %s rst=%0b est=%0b fl=%0b rs=%0d rt=%0d -> pw=%0b iw=%0b bb=%0b fa=%0b fb=%0b sc=%0d",
                 n_txn, tag, x.rst, x.est, x.fl, x.rs, x.rt, pc_write, ifid_write,
                 idex_bubble, fwd_a, fwd_b, stall_count);
        n_txn++;
    endtask

    // Newest matching producer wins; a load in EX cannot supply its value yet.
    function automatic logic [1:0] m_sel(input logic used, input logic [4:0] r);
        if (!used || r == 5'd0) return 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (m_stage[k].rw && m_stage[k].rd == r && !(k == 0 && m_stage[k].mr))
                return (k == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic model_step(input in_t x, output exp_t e);
        logic  lu;
        prod_t bubble;
        bubble = '{rw: 1'b0, mr: 1'b0, rd: 5'd0};
        e.pw = 1'b1; e.iw = 1'b1; e.bb = 1'b0;
        if (x.rst) begin
            m_stage[0] = bubble; m_stage[1] = bubble;
            m_fa = 2'b00; m_fb = 2'b00; m_cnt = 0;
        end else begin
            lu = x.v && m_stage[0].mr && m_stage[0].rw && m_stage[0].rd != 5'd0 &&
                 ((x.urs && x.rs == m_stage[0].rd) || (x.urt && x.rt == m_stage[0].rd));
            if (x.est) begin
                e.pw = 1'b0; e.iw = 1'b0;
            end else if (x.fl || lu) begin
                e.pw = x.fl; e.iw = x.fl; e.bb = 1'b1;
                m_stage[1] = m_stage[0]; m_stage[0] = bubble;
                m_fa = 2'b00; m_fb = 2'b00;
                if (!x.fl && m_cnt < CNT_MAX) m_cnt++;
            end else begin
                m_fa = m_sel(x.urs, x.rs);
                m_fb = m_sel(x.urt, x.rt);
                m_stage[1] = m_stage[0];
                m_stage[0] = '{rw: x.v & x.rw, mr: x.v & x.mr, rd: x.rd};
            end
        end
        e.fa = m_fa; e.fb = m_fb; e.sc = m_cnt;
    endtask

    initial begin
        vec_t tbl[$];
        in_t  x;
        exp_t e;
        int   sat;

        reset = 1'b1; ext_stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_rd = '0; id_regwrite = 1'b0; id_memread = 1'b0;

        //                 rst est fl v  rs rt urs urt rd rw mr   pw iw bb fa fb sc
        tbl.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 0, 0, 0, 0, 3, 1, 0,  1, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 3, 9, 1, 1, 8, 1, 0,  1, 1, 0, 2, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 0, 0, 0, 0, 4, 1, 0,  1, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 0, 0, 0, 0, 4, 1, 0,  1, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 8, 4, 1, 1, 7, 1, 0,  1, 1, 0, 0, 2, 0));
        tbl.push_back(row(0, 0, 0, 1, 0, 4, 0, 1, 0, 0, 0,  1, 1, 0, 0, 1, 0));
        tbl.push_back(row(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 1,  1, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 0, 0, 1, 0, 5, 0, 0,  1, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 0, 0, 0, 0, 5, 1, 1,  1, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 5, 2, 1, 1, 6, 1, 0,  0, 0, 1, 0, 0, 1));
        tbl.push_back(row(0, 0, 0, 1, 5, 2, 1, 1, 6, 1, 0,  1, 1, 0, 1, 0, 1));
        tbl.push_back(row(0, 0, 0, 1, 6, 0, 1, 0, 5, 1, 1,  1, 1, 0, 2, 0, 1));
        tbl.push_back(row(0, 1, 0, 1, 5, 0, 1, 0, 6, 1, 0,  0, 0, 0, 2, 0, 1));
        tbl.push_back(row(0, 1, 0, 1, 5, 0, 1, 0, 6, 1, 0,  0, 0, 0, 2, 0, 1));
        tbl.push_back(row(0, 1, 0, 1, 5, 0, 1, 0, 6, 1, 0,  0, 0, 0, 2, 0, 1));
        tbl.push_back(row(0, 0, 0, 1, 5, 0, 1, 0, 6, 1, 0,  0, 0, 1, 0, 0, 2));
        tbl.push_back(row(0, 0, 0, 1, 5, 0, 1, 0, 6, 1, 0,  1, 1, 0, 1, 0, 2));
        tbl.push_back(row(0, 0, 0, 1, 0, 0, 0, 0, 5, 1, 1,  1, 1, 0, 0, 0, 2));
        tbl.push_back(row(0, 0, 1, 1, 5, 0, 1, 0, 6, 1, 0,  1, 1, 1, 0, 0, 2));
        tbl.push_back(row(0, 0, 0, 1, 5, 0, 1, 0, 9, 1, 0,  1, 1, 0, 1, 0, 2));
        tbl.push_back(row(1, 0, 0, 1, 9, 0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 9, 0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0));

        foreach (tbl[k]) apply(tbl[k].i, tbl[k].e, "dir");

        // Back-to-back load / dependent pairs drive the counter past its ceiling
        sat = 0;
        for (int k = 0; k < CNT_MAX + 6; k++) begin
            x = tbl[10].i;
            x.rd = 5'd3;
            e = '{pw: 1'b1, iw: 1'b1, bb: 1'b0, fa: 2'b00, fb: 2'b00, sc: sat};
            apply(x, e, "sat_ld");
            x = tbl[9].i;
            x.rs = 5'd3;
            sat = (sat < CNT_MAX) ? sat + 1 : CNT_MAX;
            e = '{pw: 1'b0, iw: 1'b0, bb: 1'b1, fa: 2'b00, fb: 2'b00, sc: sat};
            apply(x, e, "sat_lu");
        end

        for (int k = 0; k < 1200; k++) begin
            x.rst = (k == 0) || ($urandom_range(0, 99) < 2);
            x.est = ($urandom_range(0, 99) < 10);
            x.fl  = ($urandom_range(0, 99) < 10);
            x.v   = ($urandom_range(0, 9) < 8);
            x.rs  = 5'($urandom_range(0, 3));
            x.rt  = 5'($urandom_range(0, 3));
            x.urs = ($urandom_range(0, 9) < 7);
            x.urt = ($urandom_range(0, 9) < 7);
            x.rd  = 5'($urandom_range(0, 3));
            x.rw  = ($urandom_range(0, 9) < 7);
            x.mr  = ($urandom_range(0, 9) < 4);
            model_step(x, e);
            apply(x, e, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
